psum_accum: RTL and testbench

Partial-sum accumulator placed directly downstream of the ADDER tree. It sums successive 864-bit `Psum` beats, one per input-channel round, into 36 signed 32-bit lane accumulators. After a programmed beat count it shifts, clamps and saturates each lane to 16 bits. The finished tile is handed to the output write-back stage over a valid/ready handshake through a single holding register.

---
 rtl/psum_accum_if.sv | 30 +++
 rtl/psum_accum.sv | 179 +++++++++++++++++
 tb/tb_psum_accum.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_if.sv
// psum_accum_if: groups the job-control, Psum beat and output-tile handshake
// signals of the partial-sum accumulator. The master side is the job
// controller / ADDER / write-back consumer; the slave side is psum_accum.
interface psum_accum_if #(
  parameter int LANES = 36,
  parameter int PW    = 24,
  parameter int OW    = 16
) ();
  logic                  start;
  logic [7:0]            acc_len;
  logic [7:0]            tile_num;
  logic [4:0]            shift;
  logic                  Psum_valid;
  logic [LANES*PW-1:0]   Psum;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OW-1:0]   out_data;
  logic                  busy;
  logic                  overrun;

  modport master (
    output start, acc_len, tile_num, shift, Psum_valid, Psum, out_ready,
    input  out_valid, out_data, busy, overrun
  );

  modport slave (
    input  start, acc_len, tile_num, shift, Psum_valid, Psum, out_ready,
    output out_valid, out_data, busy, overrun
  );
endinterface

// File: rtl/psum_accum.sv
// psum_accum: sums successive Psum beats into LANES signed AW-bit lane
// accumulators, then shifts, (optionally) clamps and saturates each lane to
// OW bits and hands the tile to write-back through one holding register.
// Optional feature macro: PSUM_RELU_EN (negative shifted lanes clamp to 0).
module psum_accum #(
  parameter int LANES = 36,
  parameter int PW    = 24,
  parameter int AW    = 32,
  parameter int OW    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  psum_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  state_t                state_q, state_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            tile_q, tile_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            tiles_q, tiles_d;
  logic [4:0]            shift_q, shift_d;
  logic                  overrun_q, overrun_d;
  logic signed [AW-1:0]  acc_q   [LANES];
  logic signed [AW-1:0]  acc_d   [LANES];
  logic                  out_valid_q, out_valid_d;
  logic [LANES*OW-1:0]   out_data_q, out_data_d;
  logic [LANES*OW-1:0]   tile_conv;

  logic beat_en, last_beat, last_tile, hold_free, xfer;

  // Shift, optional ReLU clamp, then signed saturation of one lane.
  function automatic logic signed [OW-1:0] convert(
    input logic signed [AW-1:0] a,
    input logic [4:0]           sh
  );
    logic signed [AW-1:0] v;
    v = a >>> sh;
`ifdef PSUM_RELU_EN
    if (v < 0) v = '0;
`endif
    if (v > SAT_MAX)      v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return v[OW-1:0];
  endfunction

  // The holding register can take a tile when empty or being drained now.
  assign beat_en   = (state_q == ACC) && bus.Psum_valid;
  assign last_beat = (beat_q == len_q - 8'd1);
  assign last_tile = (tile_q == tiles_q - 8'd1);
  assign hold_free = !out_valid_q || bus.out_ready;
  assign xfer      = hold_free && ((beat_en && last_beat) || (state_q == WAIT));

  // Lane arithmetic: beat 0 loads, later beats wrap-add; convert the result.
  always_comb begin
    logic signed [PW-1:0] lane;
    logic signed [AW-1:0] ext;
    tile_conv = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = bus.Psum[i*PW +: PW];
      ext  = {{(AW-PW){lane[PW-1]}}, lane};
      if (beat_en)
        acc_d[i] = (beat_q == 8'd0) ? ext : acc_q[i] + ext;
      else
        acc_d[i] = acc_q[i];
      tile_conv[i*OW +: OW] = convert(acc_d[i], shift_q);
    end
  end

  // Next-state, counters, captured configuration and overrun flag.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tile_d    = tile_q;
    len_d     = len_q;
    tiles_d   = tiles_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d     = (bus.acc_len  == 8'd0) ? 8'd1 : bus.acc_len;
          tiles_d   = (bus.tile_num == 8'd0) ? 8'd1 : bus.tile_num;
          shift_d   = bus.shift;
          beat_d    = 8'd0;
          tile_d    = 8'd0;
          overrun_d = 1'b0;
          state_d   = ACC;
        end else if (bus.Psum_valid) begin
          overrun_d = 1'b1;
        end
      end
      ACC: begin
        if (beat_en) begin
          beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
          if (last_beat) begin
            if (hold_free) begin
              tile_d  = tile_q + 8'd1;
              state_d = last_tile ? IDLE : ACC;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (bus.Psum_valid) overrun_d = 1'b1;
        if (hold_free) begin
          tile_d  = tile_q + 8'd1;
          state_d = last_tile ? IDLE : ACC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: load on transfer, otherwise drain on ready.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = tile_conv;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      tile_q    <= '0;
      len_q     <= '0;
      tiles_q   <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      tile_q    <= tile_d;
      len_q     <= len_d;
      tiles_q   <= tiles_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
    end
  end

  // Lane accumulators update only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else if (beat_en) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: scenario tasks drive psum_accum; expected tiles are pushed
// to a queue as final beats are driven and popped when a tile is consumed.
module tb_psum_accum;
  localparam int LANES = 36;
  localparam int PW    = 24;
  localparam int AW    = 32;
  localparam int OW    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psum_accum_if #(.LANES(LANES), .PW(PW), .OW(OW)) ifc ();

  psum_accum #(.LANES(LANES), .PW(PW), .AW(AW), .OW(OW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_acc [LANES];
  logic [LANES*OW-1:0] exp_q [$];

  function automatic logic [LANES*PW-1:0] mk_psum(input int base, input int step);
    logic [LANES*PW-1:0] r;
    int v;
    for (int i = 0; i < LANES; i++) begin
      v = base + i*step;
      r[i*PW +: PW] = PW'(v);
    end
    return r;
  endfunction

  function automatic logic [LANES*OW-1:0] rep(input int v);
    logic [LANES*OW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*OW +: OW] = OW'(v);
    return r;
  endfunction

  // Reference conversion in plain integer arithmetic.
  function automatic logic [LANES*OW-1:0] mk_exp(input int sh);
    logic [LANES*OW-1:0] r;
    int s;
    for (int i = 0; i < LANES; i++) begin
      s = m_acc[i] >>> sh;
`ifdef PSUM_RELU_EN
      if (s < 0) s = 0;
`endif
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      r[i*OW +: OW] = OW'(s);
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int base, input int step, input bit first);
    ifc.Psum_valid = 1'b1;
    ifc.Psum       = mk_psum(base, step);
    for (int i = 0; i < LANES; i++)
      m_acc[i] = first ? (base + i*step) : (m_acc[i] + base + i*step);
    cyc();
    ifc.Psum_valid = 1'b0;
  endtask

  task automatic start_job(input int len, input int tiles, input int sh);
    ifc.acc_len  = 8'(len);
    ifc.tile_num = 8'(tiles);
    ifc.shift    = 5'(sh);
    ifc.start    = 1'b1;
    cyc();
    ifc.start    = 1'b0;
  endtask

  // Scoreboard: every consumed tile must match the oldest expected tile.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_tile: got %h, required no tile", ifc.out_data);
      end else begin
        logic [LANES*OW-1:0] e;
        e = exp_q.pop_front();
        if (ifc.out_data !== e) begin
          n_bad++;
          $display("FAIL sb_tile_data: got %h, required %h", ifc.out_data, e);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, required 0", ifc.out_valid); end
    n_cmp++; if (ifc.out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %h, required 0", ifc.out_data); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", ifc.busy); end
    n_cmp++; if (ifc.overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b, required 0", ifc.overrun); end
    rst_n = 1'b1;
    cyc();
    ifc.Psum_valid = 1'b1;
    ifc.Psum       = mk_psum(5555, 3);
    cyc();
    ifc.Psum_valid = 1'b0;
    n_cmp++; if (ifc.overrun !== 1'b1) begin n_bad++; $display("FAIL idle_overrun: got %b, required 1", ifc.overrun); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b, required 0", ifc.busy); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_out_valid: got %b, required 0", ifc.out_valid); end
  endtask

  task automatic test_basic();
    ifc.out_ready = 1'b1;
    start_job(3, 1, 0);
    n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_rise: got %b, required 1", ifc.busy); end
    n_cmp++; if (ifc.overrun !== 1'b0) begin n_bad++; $display("FAIL basic_overrun_clr: got %b, required 0", ifc.overrun); end
    drive_beat(100, 0, 1'b1);
    drive_beat(200, 0, 1'b0);
    drive_beat(-50, 0, 1'b0);
    exp_q.push_back(mk_exp(0));
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid: got %b, required 1", ifc.out_valid); end
    n_cmp++; if (ifc.out_data !== rep(250)) begin n_bad++; $display("FAIL basic_data: got %h, required %h", ifc.out_data, rep(250)); end
    cyc();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall: got %b, required 0", ifc.busy); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drained: got %b, required 0", ifc.out_valid); end
  endtask

  task automatic test_saturation();
    int neg_exp;
`ifdef PSUM_RELU_EN
    neg_exp = 0;
`else
    neg_exp = -32768;
`endif
    start_job(2, 1, 4);
    drive_beat(32'h007F_FFFF, 0, 1'b1);
    drive_beat(32'h007F_FFFF, 0, 1'b0);
    exp_q.push_back(mk_exp(4));
    n_cmp++; if (ifc.out_data !== rep(32767)) begin n_bad++; $display("FAIL sat_pos: got %h, required %h", ifc.out_data, rep(32767)); end
    cyc();
    start_job(2, 1, 4);
    drive_beat(-8388608, 0, 1'b1);
    drive_beat(-8388608, 0, 1'b0);
    exp_q.push_back(mk_exp(4));
    n_cmp++; if (ifc.out_data !== rep(neg_exp)) begin n_bad++; $display("FAIL sat_neg: got %h, required %h", ifc.out_data, rep(neg_exp)); end
    cyc();
  endtask

  task automatic test_lanes();
    start_job(3, 1, 2);
    drive_beat(-20000, 1111, 1'b1);
    drive_beat(4000000, -230000, 1'b0);
    drive_beat(-123456, 7000, 1'b0);
    exp_q.push_back(mk_exp(2));
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_bad++; $display("FAIL lanes_out_valid: got %b, required 1", ifc.out_valid); end
    cyc();
  endtask

  task automatic test_back_to_back();
    start_job(2, 3, 1);
    for (int t = 0; t < 3; t++) begin
      drive_beat(300*t - 700, 37 + t, 1'b1);
      n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_mid: got %b, required 1", ifc.busy); end
      drive_beat(-11*t + 50, -5, 1'b0);
      exp_q.push_back(mk_exp(1));
      n_cmp++; if (ifc.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_out_valid: got %b, required 1", ifc.out_valid); end
    end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b, required 0", ifc.busy); end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [LANES*OW-1:0] exp_a, exp_b;
    ifc.out_ready = 1'b0;
    start_job(1, 2, 0);
    drive_beat(1234, -17, 1'b1);
    exp_a = mk_exp(0);
    exp_q.push_back(exp_a);
    drive_beat(-4321, 29, 1'b1);
    exp_b = mk_exp(0);
    exp_q.push_back(exp_b);
    n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL bp_wait_busy: got %b, required 1", ifc.busy); end
    n_cmp++; if (ifc.out_data !== exp_a) begin n_bad++; $display("FAIL bp_hold_data: got %h, required %h", ifc.out_data, exp_a); end
    ifc.Psum_valid = 1'b1;
    ifc.Psum       = mk_psum(999, 999);
    cyc();
    ifc.Psum_valid = 1'b0;
    n_cmp++; if (ifc.overrun !== 1'b1) begin n_bad++; $display("FAIL bp_wait_overrun: got %b, required 1", ifc.overrun); end
    n_cmp++; if (ifc.out_data !== exp_a) begin n_bad++; $display("FAIL bp_stable_data: got %h, required %h", ifc.out_data, exp_a); end
    ifc.out_ready = 1'b1;
    cyc();
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_cont: got %b, required 1", ifc.out_valid); end
    n_cmp++; if (ifc.out_data !== exp_b) begin n_bad++; $display("FAIL bp_tile1_data: got %h, required %h", ifc.out_data, exp_b); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy_end: got %b, required 0", ifc.busy); end
    cyc();
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b, required 0", ifc.out_valid); end
  endtask

  task automatic test_zero_cfg();
    start_job(0, 0, 0);
    n_cmp++; if (ifc.overrun !== 1'b0) begin n_bad++; $display("FAIL zero_overrun_clr: got %b, required 0", ifc.overrun); end
    drive_beat(321, -9, 1'b1);
    exp_q.push_back(mk_exp(0));
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_bad++; $display("FAIL zero_out_valid: got %b, required 1", ifc.out_valid); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b, required 0", ifc.busy); end
    cyc();
    start_job(2, 1, 0);
    drive_beat(10, 1, 1'b1);
    start_job(5, 9, 3);
    n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL ign_start_busy: got %b, required 1", ifc.busy); end
    n_cmp++; if (ifc.overrun !== 1'b0) begin n_bad++; $display("FAIL ign_start_overrun: got %b, required 0", ifc.overrun); end
    drive_beat(20, 2, 1'b0);
    exp_q.push_back(mk_exp(0));
    n_cmp++; if (ifc.out_valid !== 1'b1) begin n_bad++; $display("FAIL ign_start_out_valid: got %b, required 1", ifc.out_valid); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL ign_start_busy_end: got %b, required 0", ifc.busy); end
    cyc();
  endtask

  task automatic test_reset_mid();
    start_job(4, 1, 0);
    drive_beat(1000, 7, 1'b1);
    drive_beat(2000, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b, required 0", ifc.busy); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b, required 0", ifc.out_valid); end
    cyc();
    rst_n = 1'b1;
    cyc();
    start_job(2, 1, 0);
    drive_beat(7, 0, 1'b1);
    drive_beat(8, 0, 1'b0);
    exp_q.push_back(mk_exp(0));
    n_cmp++; if (ifc.out_data !== rep(15)) begin n_bad++; $display("FAIL rmid_fresh_sum: got %h, required %h", ifc.out_data, rep(15)); end
    cyc();
  endtask

  initial begin
    ifc.start      = 1'b0;
    ifc.acc_len    = '0;
    ifc.tile_num   = '0;
    ifc.shift      = '0;
    ifc.Psum_valid = 1'b0;
    ifc.Psum       = '0;
    ifc.out_ready  = 1'b0;
    for (int i = 0; i < LANES; i++) m_acc[i] = 0;

    test_reset();
    test_basic();
    test_saturation();
    test_lanes();
    test_back_to_back();
    test_backpressure();
    test_zero_cfg();
    test_reset_mid();
    repeat (3) cyc();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending tiles, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
